verificador_m_de_n: RTL and testbench



---
 rtl/verificador_pkg.sv | 16 +
 rtl/verificador_m_de_n_contador_uns.sv | 20 ++
 rtl/verificador_m_de_n.sv | 109 ++++++++++
 tb/tb_verificador_m_de_n.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/verificador_pkg.sv
// Shared parameters, width helper and count type for the M-of-N code checker.
package verificador_pkg;

    localparam int unsigned DEF_N         = 5;
    localparam int unsigned DEF_M         = 2;
    localparam int unsigned DEF_CNT_W     = 8;
    localparam int unsigned DEF_ALARM_RUN = 3;

    // Bits needed to hold a count of 0..n ones.
    function automatic int unsigned cw(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    typedef logic [cw(DEF_N)-1:0] count_t;

endpackage

// File: rtl/verificador_m_de_n_contador_uns.sv
// Combinational popcount of a W-bit slice, one adder stage per input bit.
module contador_uns
    import verificador_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0]     bits,
    output logic [cw(W)-1:0] count
);

    localparam int unsigned OW = cw(W);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < W; i++) begin
            count = count + OW'(bits[i]);
        end
    end

endmodule

// File: rtl/verificador_m_de_n.sv
// Streaming M-of-N code checker: two-stage popcount pipeline with valid/ready
// handshakes, saturating error counter and sticky burst alarm.
module verificador_m_de_n
    import verificador_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned M         = DEF_M,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned ALARM_RUN = DEF_ALARM_RUN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_erro,
    output logic [cw(N)-1:0] out_count,
    output logic [CNT_W-1:0] err_total,
    output logic             alarm,
    input  logic             clr_stats
);

    localparam int unsigned CW   = cw(N);
    localparam int unsigned LO_W = N / 2;
    localparam int unsigned HI_W = N - N / 2;
    localparam int unsigned LCW  = cw(LO_W);
    localparam int unsigned HCW  = cw(HI_W);
    localparam logic [7:0]  AR8  = 8'(ALARM_RUN);

    if (N < 2 || N > 32 || M > N || ALARM_RUN < 1 || ALARM_RUN > 255 || CNT_W < 1) begin : g_bad_params
        $error("verificador_m_de_n: illegal parameter combination");
    end

    logic [LCW-1:0] lo_c, s1_lo;
    logic [HCW-1:0] hi_c, s1_hi;
    logic           s1_v;
    logic [CW-1:0]  sum;
    logic           adv1, adv2, out_xfer;
    logic [7:0]     run;

    contador_uns #(.W(LO_W)) u_lo (.bits(in_code[LO_W-1:0]), .count(lo_c));
    contador_uns #(.W(HI_W)) u_hi (.bits(in_code[N-1:LO_W]), .count(hi_c));

    always_comb begin
        adv2     = !out_valid || out_ready;
        adv1     = !s1_v || adv2;
        in_ready = adv1;
        out_xfer = out_valid && out_ready;
        sum      = CW'(s1_lo) + CW'(s1_hi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_lo <= '0;
            s1_hi <= '0;
        end else if (adv1) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_lo <= lo_c;
                s1_hi <= hi_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_erro  <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_count <= sum;
                out_erro  <= (sum != CW'(M));
            end
        end
    end

    // A clear wins over a simultaneous delivery; that word is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_total <= '0;
            run       <= '0;
            alarm     <= 1'b0;
        end else if (clr_stats) begin
            err_total <= '0;
            run       <= '0;
            alarm     <= 1'b0;
        end else if (out_xfer) begin
            if (out_erro) begin
                if (err_total != '1) begin
                    err_total <= err_total + CNT_W'(1);
                end
                if (run != AR8) begin
                    run <= run + 8'd1;
                end
                if (run >= AR8 - 8'd1) begin
                    alarm <= 1'b1;
                end
            end else begin
                run <= '0;
            end
        end
    end

endmodule

// File: tb/tb_verificador_m_de_n.sv
// Scoreboarded bench for verificador_m_de_n: random and directed traffic on a
// 5-bit/M=2 instance plus directed corner checks on an 8-bit/M=0 instance.
module tb_verificador_m_de_n;

    localparam int N  = 5;
    localparam int M  = 2;
    localparam int CW = 4;
    localparam int AR = 3;
    localparam int SAT = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_erro, alarm, clr_stats;
    logic [4:0] in_code;
    logic [2:0] out_count;
    logic [3:0] err_total;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, erro8, alarm8, clr8;
    logic [7:0] code8;
    logic [3:0] count8;
    logic [1:0] err8;

    always #5 clk = ~clk;

    verificador_m_de_n #(.N(N), .M(M), .CNT_W(CW), .ALARM_RUN(AR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_erro(out_erro), .out_count(out_count), .err_total(err_total),
        .alarm(alarm), .clr_stats(clr_stats)
    );

    verificador_m_de_n #(.N(8), .M(0), .CNT_W(2), .ALARM_RUN(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_code(code8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_erro(erro8), .out_count(count8), .err_total(err8),
        .alarm(alarm8), .clr_stats(clr8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard state: words in flight and error flags of words delivered since last clear.
    typedef struct {
        int cnt;
        bit erro;
        int cyc;
    } exp_t;

    exp_t q[$];
    bit   hist[$];
    int   cyc = 0;
    bit   hold_prev = 0;
    int   prev_cnt, prev_erro;
    exp_t h;

    function automatic int exp_err();
        int s = 0;
        foreach (hist[i]) s += int'(hist[i]);
        return (s > SAT) ? SAT : s;
    endfunction

    function automatic int exp_alarm();
        int r = 0;
        foreach (hist[i]) begin
            if (hist[i]) begin
                r++;
                if (r >= AR) return 1;
            end else begin
                r = 0;
            end
        end
        return 0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n === 1'b1) begin
            check("err_total", int'(err_total), exp_err());
            check("alarm", int'(alarm), exp_alarm());
            check("in_ready", int'(in_ready), int'(!(q.size() == 2 && !out_ready)));
            check("out_valid", int'(out_valid), int'(q.size() > 0 && cyc >= q[0].cyc + 2));
            if (hold_prev) begin
                check("hold_count", int'(out_count), prev_cnt);
                check("hold_erro", int'(out_erro), prev_erro);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    h = q.pop_front();
                    check("out_count", int'(out_count), h.cnt);
                    check("out_erro", int'(out_erro), int'(h.erro));
                    if (!clr_stats) hist.push_back(h.erro);
                end
            end
            if (clr_stats) hist.delete();
            if (in_valid && in_ready)
                q.push_back('{cnt: $countones(in_code), erro: ($countones(in_code) != M), cyc: cyc});
            hold_prev = out_valid && !out_ready;
            prev_cnt  = int'(out_count);
            prev_erro = int'(out_erro);
        end else begin
            hold_prev = 0;
        end
    end

    task automatic push(input logic [4:0] c);
        bit acc = 0;
        in_valid = 1'b1;
        in_code  = c;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int errs8 = 0, run8 = 0, alarm8m = 0;

    task automatic send8(input logic [7:0] c, input bit clr);
        int cnt;
        cnt       = $countones(c);
        in_valid8 = 1'b1;
        code8     = c;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        check("n8_out_valid", int'(out_valid8), 1);
        check("n8_out_count", int'(count8), cnt);
        check("n8_out_erro", int'(erro8), int'(cnt != 0));
        clr8 = clr;
        @(posedge clk); #1;
        clr8 = 1'b0;
        if (clr) begin
            errs8 = 0; run8 = 0; alarm8m = 0;
        end else if (cnt != 0) begin
            errs8++; run8++;
            if (run8 >= 2) alarm8m = 1;
        end else begin
            run8 = 0;
        end
        check("n8_err_total", int'(err8), (errs8 > 3) ? 3 : errs8);
        check("n8_alarm", int'(alarm8), alarm8m);
    endtask

    logic [4:0] bp_words [3];
    int idx;

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_code = '0; out_ready = 1'b1; clr_stats = 0;
        in_valid8 = 0; code8 = '0; out_ready8 = 1'b1; clr8 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_erro", int'(out_erro), 0);
        check("rst_err_total", int'(err_total), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_in_ready8", int'(in_ready8), 1);
        rst_n = 1'b1;

        push(5'b10010);
        idle(3);
        push(5'b11100);
        push(5'b00000);
        push(5'b11111);
        idle(4);

        bp_words[0] = 5'b00011; bp_words[1] = 5'b01100; bp_words[2] = 5'b10001;
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_code = bp_words[idx];
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepts", idx, 2);
        out_ready = 1'b1;
        push(bp_words[2]);
        idle(4);

        for (int k = 0; k < 800; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_code   = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_stats = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        clr_stats = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_code = 5'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_out_valid", int'(out_valid), 0);
        check("amid_in_ready", int'(in_ready), 1);
        check("amid_err_total", int'(err_total), 0);
        check("amid_alarm", int'(alarm), 0);
        q.delete();
        hist.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(5'b10100);
        idle(5);
        check("drain_empty", q.size(), 0);

        send8(8'h00, 0);
        send8(8'hFF, 0);
        send8(8'hFF, 0);
        send8(8'h0F, 0);
        send8(8'h80, 0);
        send8(8'hFE, 0);
        send8(8'h00, 0);
        send8(8'hFF, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
